// File: rtl/move_stack_writer.sv
// rtl/move_stack_writer.sv - 2-bit move stack that bulk-loads the move queue on commit
// Records solver moves with push/pop backtracking, then presents the array and length for one cycle.
module move_stack_writer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] move_in,
  input  logic       commit,
  output logic       ld,
  output logic [1:0] ld_data [0:256],
  output logic [8:0] rear_index_out,
  output logic [8:0] count,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       done
);

  typedef enum logic [1:0] {RECORD, LOAD, DONE} state_t;

  state_t     state;
  logic [1:0] mem [0:255];
  logic [7:0] top_idx;
  logic [7:0] next_idx;

  assign top_idx  = count[7:0] - 8'd1;
  assign next_idx = count[7:0];
  assign empty    = (count == 9'd0);
  assign full     = count[8];
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= RECORD;
      ld             <= 1'b0;
      count          <= 9'd0;
      rear_index_out <= 9'd0;
      overflow       <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= 2'b00;
    end else if (clear) begin
      state    <= RECORD;
      ld       <= 1'b0;
      count    <= 9'd0;
      overflow <= 1'b0;
    end else begin
      case (state)
        RECORD: begin
          if (commit) begin
            state          <= LOAD;
            ld             <= 1'b1;
            rear_index_out <= count;
          end else if (push && pop && !empty) begin
            mem[top_idx] <= move_in;
          end else if (push) begin
            // A push at depth 256 is dropped and remembered until clear/reset.
            if (full) begin
              overflow <= 1'b1;
            end else begin
              mem[next_idx] <= move_in;
              count         <= count + 9'd1;
            end
          end else if (pop && !empty) begin
            count <= count - 9'd1;
          end
        end
        LOAD: begin
          state <= DONE;
          ld    <= 1'b0;
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= RECORD;
          ld    <= 1'b0;
        end
      endcase
    end
  end

  // Slot 256 exists only to match the queue's load port width.
  always_comb begin
    for (int i = 0; i < 256; i++) ld_data[i] = mem[i];
    ld_data[256] = 2'b00;
  end

endmodule

// File: tb/tb_move_stack_writer.sv
// tb/tb_move_stack_writer.sv - self-checking bench for move_stack_writer
// Directed test-plan steps plus random traffic, checked against a queue-based stack model.
module tb_move_stack_writer;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       push;
  logic       pop;
  logic [1:0] move_in;
  logic       commit;
  logic       ld;
  logic [1:0] ld_data [0:256];
  logic [8:0] rear_index_out;
  logic [8:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       done;

  move_stack_writer dut (
    .clk(clk), .rst(rst), .clear(clear), .push(push), .pop(pop),
    .move_in(move_in), .commit(commit), .ld(ld), .ld_data(ld_data),
    .rear_index_out(rear_index_out), .count(count), .empty(empty),
    .full(full), .overflow(overflow), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: the path is a queue used as a stack; phase 0=recording, 1=loading, 2=finished.
  logic [1:0] stk [$];
  int         m_phase;
  int         m_rear;
  bit         m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    m_phase = 0;
    m_rear  = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_update(input bit c, input bit p, input bit po,
                              input logic [1:0] mv, input bit cm);
    if (c) begin
      stk.delete();
      m_ovf   = 1'b0;
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (cm) begin
        m_rear  = stk.size();
        m_phase = 1;
      end else if (p && po && stk.size() > 0) begin
        stk[stk.size()-1] = mv;
      end else if (p) begin
        if (stk.size() < 256) stk.push_back(mv);
        else m_ovf = 1'b1;
      end else if (po && stk.size() > 0) begin
        void'(stk.pop_back());
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end
  endtask

  task automatic check_outputs();
    chk("count", count, stk.size());
    chk("empty", empty, stk.size() == 0);
    chk("full", full, stk.size() == 256);
    chk("overflow", overflow, m_ovf);
    chk("ld", ld, m_phase == 1);
    chk("done", done, m_phase == 2);
    chk("rear_index_out", rear_index_out, m_rear);
    for (int i = 0; i < stk.size(); i++) chk($sformatf("ld_data[%0d]", i), ld_data[i], stk[i]);
  endtask

  task automatic step(input bit c, input bit p, input bit po,
                      input logic [1:0] mv, input bit cm);
    clear = c; push = p; pop = po; move_in = mv; commit = cm;
    @(posedge clk);
    model_update(c, p, po, mv, cm);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(0, 0, 0, 2'b00, 0);
  endtask

  int pulses;

  initial begin
    rst = 1'b1; clear = 0; push = 0; pop = 0; move_in = 2'b00; commit = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i <= 256; i++) chk("reset ld_data", ld_data[i], 2'b00);
    check_outputs();
    rst = 1'b0;
    idle();

    // Three pushes then commit
    step(0, 1, 0, 2'b10, 0);
    step(0, 1, 0, 2'b01, 0);
    step(0, 1, 0, 2'b11, 0);
    step(0, 0, 0, 2'b00, 1);
    chk("tp1 ld high", ld, 1'b1);
    chk("tp1 rear", rear_index_out, 9'd3);
    idle();
    chk("tp1 ld single", ld, 1'b0);
    chk("tp1 done", done, 1'b1);

    // Push/pop backtrack
    step(1, 0, 0, 2'b00, 0);
    step(0, 1, 0, 2'b00, 0);
    step(0, 1, 0, 2'b01, 0);
    step(0, 1, 0, 2'b10, 0);
    step(0, 0, 1, 2'b00, 0);
    step(0, 1, 0, 2'b11, 0);
    step(0, 0, 0, 2'b00, 1);
    chk("tp2 ld_data[2]", ld_data[2], 2'b11);
    idle();

    // Replace-top, at depth 2 and at depth 0
    step(1, 0, 0, 2'b00, 0);
    step(0, 1, 0, 2'b11, 0);
    step(0, 1, 0, 2'b10, 0);
    step(0, 1, 1, 2'b01, 0);
    chk("tp3 count2", count, 9'd2);
    chk("tp3 ld_data[1]", ld_data[1], 2'b01);
    step(1, 0, 0, 2'b00, 0);
    step(0, 1, 1, 2'b01, 0);
    chk("tp3 count1", count, 9'd1);
    chk("tp3 ld_data[0]", ld_data[0], 2'b01);

    // Fill to 256, then one more push overflows
    step(1, 0, 0, 2'b00, 0);
    for (int i = 0; i < 257; i++) step(0, 1, 0, 2'($urandom), 0);
    chk("tp4 count", count, 9'd256);
    chk("tp4 overflow", overflow, 1'b1);
    step(0, 0, 0, 2'b00, 1);
    chk("tp4 rear", rear_index_out, 9'h100);
    chk("tp4 ld_data[256]", ld_data[256], 2'b00);
    idle();

    // Pop at empty, commit with push, commit held
    step(1, 0, 0, 2'b00, 0);
    step(0, 0, 1, 2'b00, 0);
    chk("tp5 empty pop count", count, 9'd0);
    chk("tp5 empty pop ovf", overflow, 1'b0);
    step(0, 1, 0, 2'b01, 0);
    step(0, 1, 0, 2'b10, 0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 2'b11, 1);
      if (ld) pulses++;
    end
    idle();
    if (ld) pulses++;
    chk("tp5 ld pulses", pulses, 1);
    chk("tp5 rear", rear_index_out, 9'd2);

    // Async reset during LOAD, then clear from DONE
    step(1, 0, 0, 2'b00, 0);
    step(0, 1, 0, 2'b10, 0);
    step(0, 0, 0, 2'b00, 1);
    chk("tp6 in load", ld, 1'b1);
    rst = 1'b1;
    #1;
    chk("tp6 async ld", ld, 1'b0);
    chk("tp6 async count", count, 9'd0);
    chk("tp6 async empty", empty, 1'b1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 1, 0, 2'b01, 0);
    step(0, 0, 0, 2'b00, 1);
    idle();
    chk("tp6 done", done, 1'b1);
    step(0, 1, 1, 2'b10, 1);
    step(1, 0, 0, 2'b00, 0);
    chk("tp6 done cleared", done, 1'b0);
    step(0, 1, 0, 2'b11, 0);
    chk("tp6 ld_data[0]", ld_data[0], 2'b11);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0, 2'($urandom), $urandom_range(0, 19) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/move_stack_writer.md
# move_stack_writer

Producer-side companion to the 2-bit move queue. A maze-solver datapath pushes one 2-bit move per cycle, and backtracks by popping. On commit, the block presents the whole move array plus its length for one cycle, in the bulk-load format the move queue accepts (`ld`, `ld_data`, `rear_index_in`). It sits between the solver FSM and the move queue, and holds the path as a stack until the solver finishes.

## Interface
- No parameters. Depth is fixed at 256 usable entries; the array is sized 0..256 to match the queue's load port.
- `clk` — input, 1 — rising-edge clock.
- `rst` — input, 1 — asynchronous, active-high reset.
- `clear` — input, 1 — synchronous; empties the stack and returns the block to RECORD.
- `push` — input, 1 — append `move_in` at the top.
- `pop` — input, 1 — remove the top entry (backtrack).
- `move_in` — input, 2 — move code (00/01/10/11).
- `commit` — input, 1 — path complete; start the load.
- `ld` — output, 1 — one-cycle load strobe to the queue.
- `ld_data[0:256]` — output, 2 each — move array; entry `i` is the `i`-th pushed surviving move.
- `rear_index_out` — output, 9 — number of valid moves; drives the queue's `rear_index_in`.
- `count` — output, 9 — current stack depth.
- `empty` — output, 1 — `count == 0`.
- `full` — output, 1 — `count == 256`.
- `overflow` — output, 1 — sticky; set when a push is dropped because the stack is full.
- `done` — output, 1 — high in the DONE state.

## Operation
- States:
  - RECORD: accepts push, pop and commit.
  - LOAD: `ld` = 1.
  - DONE: holds outputs and ignores push/pop/commit.
- State transitions:
  - `rst` → RECORD.
  - RECORD + `commit` → LOAD.
  - LOAD → DONE, unconditionally, after 1 cycle.
  - DONE + `clear` → RECORD.
  - `clear` in any state → RECORD with `count` = 0 and `overflow` = 0.
  - `clear` has priority over every other input.
- RECORD, decided by priority: `commit` > (`push` & `pop`) > `push` > `pop`.
  - `commit`: push and pop in the same cycle are ignored; `rear_index_out` latches `count`.
  - `push` & `pop`, `count` > 0: `mem[count-1]` ← `move_in`; `count` is unchanged (replace top).
  - `push` & `pop`, `count` = 0: treated as a plain push.
  - `push`, not full: `mem[count]` ← `move_in`; `count` += 1.
  - `push`, full: write dropped; `overflow` ← 1; `count` stays 256.
  - `pop`, not empty: `count` −= 1; the entry is not erased.
  - `pop`, empty: ignored; no flag.
- `ld_data[i]` = `mem[i]` for i in 0..255. `ld_data[256]` is constant 00. Entries at index ≥ `rear_index_out` are stale but deterministic, and the consumer ignores them.
- `count` saturates in 0..256 using 9-bit arithmetic and never wraps.

## Timing
- Reset values:
  - `ld` = 0, `count` = 0, `rear_index_out` = 0, `empty` = 1, `full` = 0, `overflow` = 0, `done` = 0.
  - All `mem` entries = 00.
  - State = RECORD.
- Registers update on the rising edge after the input is sampled. `empty`, `full` and `done` are combinational from the registered state and `count`.
- Commit latency:
  - `commit` sampled at edge N → `ld` = 1 during cycle N..N+1.
  - `ld_data` and `rear_index_out` are stable from edge N through DONE.
  - `done` = 1 from edge N+1.
- `ld` is high for exactly one cycle per commit. A `commit` held high does not re-trigger in LOAD or DONE.
- `rst` during LOAD → `ld` drops immediately (asynchronous); all state is cleared.
- `clear` during LOAD → `ld` falls at the next edge; no DONE; state = RECORD.
- Back-to-back push every cycle is supported: a new entry is visible on `ld_data` 1 cycle after its push.

## Test plan
- Reset, then push 10, 01, 11 on three consecutive cycles, then commit → `count` = 3; one-cycle `ld`; `ld_data[0..2]` = 10, 01, 11; `rear_index_out` = 3; `done` = 1 afterward.
- Push 00, 01, 10; pop; push 11; commit → `rear_index_out` = 3; `ld_data[2]` = 11.
- Simultaneous `push` & `pop` with `move_in` = 01 at `count` = 2 → `count` stays 2; `ld_data[1]` = 01. The same at `count` = 0 → `count` = 1; `ld_data[0]` = 01.
- Push 257 times → `full` = 1 after push 256; `overflow` = 1 after push 257; `count` = 256; commit gives `rear_index_out` = 256 (9'h100).
- Pop at empty → `count` = 0; `overflow` = 0. `commit` with push in the same cycle → push ignored; `rear_index_out` = prior `count`. `commit` held for 3 cycles → exactly one `ld` pulse.
- Assert `rst` asynchronously in the LOAD cycle → `ld` = 0 before the next edge; `count` = 0; `empty` = 1. Then `clear` from DONE → RECORD; a new push lands at `ld_data[0]`.
